// File: rtl/bus_uart.sv
`default_nettype none
// ============================================================================
// Module   : bus_uart
// Purpose  : Memory-mapped UART with TX/RX FIFOs, baud divisor and level irq.
// Revision : 1.0 - initial release
// ============================================================================

module bus_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);
  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;

  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (c_AW + 1)'(1);
        2'b01:   r_count <= r_count - (c_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_FULL);
endmodule

module bus_uart #(
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        select,
  input  logic [1:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic [3:0]  data_strobes,
  input  logic        read,
  input  logic        write,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  localparam logic [1:0] c_ADDR_DATA    = 2'd0;
  localparam logic [1:0] c_ADDR_STATUS  = 2'd1;
  localparam logic [1:0] c_ADDR_DIVISOR = 2'd2;
  localparam logic [1:0] c_ADDR_CONTROL = 2'd3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_HALF      = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  // Bus decode
  logic w_rd, w_wr;
  logic w_rd_data, w_wr_data, w_wr_status, w_wr_divisor, w_wr_control;
  logic w_unused_data;

  assign w_rd         = select & read;
  assign w_wr         = select & write & (data_strobes != 4'd0);
  assign w_rd_data    = w_rd & (address == c_ADDR_DATA);
  assign w_wr_data    = w_wr & (address == c_ADDR_DATA);
  assign w_wr_status  = w_wr & (address == c_ADDR_STATUS);
  assign w_wr_divisor = w_wr & (address == c_ADDR_DIVISOR);
  assign w_wr_control = w_wr & (address == c_ADDR_CONTROL);
  assign w_unused_data = ^data_in[31:16];

  // Configuration and sticky status
  logic [15:0] r_divisor;
  logic [1:0]  r_control;
  logic        r_overrun;
  logic        r_framing;
  logic        r_irq;

  // TX path
  logic        w_tx_fifo_empty, w_tx_fifo_full, w_tx_push;
  logic [7:0]  w_tx_head;
  tx_state_t   r_tx_state, w_tx_next;
  logic        w_tx_load, w_tx_bit_done, w_tx_empty;
  logic [15:0] r_tx_cnt, r_tx_div;
  logic [7:0]  r_tx_shift;
  logic [2:0]  r_tx_bitcnt;
  logic        r_tx;

  // RX path
  logic        r_rx_meta, r_rx_sync;
  logic        w_rx_fifo_empty, w_rx_fifo_full, w_rx_pop, w_rx_push;
  logic [7:0]  w_rx_head;
  rx_state_t   r_rx_state, w_rx_next;
  logic        w_rx_sample, w_rx_push_req, w_rx_frame_err, w_rx_overrun;
  logic [15:0] r_rx_cnt, r_rx_div;
  logic [7:0]  r_rx_shift;
  logic [2:0]  r_rx_bitcnt;

  assign w_tx_push = w_wr_data & ~w_tx_fifo_full;

  bus_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_load),
    .i_wdata (data_in[7:0]),
    .o_rdata (w_tx_head),
    .o_empty (w_tx_fifo_empty),
    .o_full  (w_tx_fifo_full)
  );

  // A full RX FIFO still accepts a byte when a read pops in the same cycle
  assign w_rx_pop     = w_rd_data & ~w_rx_fifo_empty;
  assign w_rx_push    = w_rx_push_req & (~w_rx_fifo_full | w_rx_pop);
  assign w_rx_overrun = w_rx_push_req & w_rx_fifo_full & ~w_rx_pop;

  bus_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_wdata (r_rx_shift),
    .o_rdata (w_rx_head),
    .o_empty (w_rx_fifo_empty),
    .o_full  (w_rx_fifo_full)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_divisor <= DEFAULT_DIVISOR;
      r_control <= 2'b00;
      r_overrun <= 1'b0;
      r_framing <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr_divisor) r_divisor <= (data_in[15:0] < 16'd2) ? 16'd2 : data_in[15:0];
      if (w_wr_control) r_control <= data_in[1:0];
      if (w_rx_overrun)                   r_overrun <= 1'b1;
      else if (w_wr_status && data_in[4]) r_overrun <= 1'b0;
      if (w_rx_frame_err)                 r_framing <= 1'b1;
      else if (w_wr_status && data_in[5]) r_framing <= 1'b0;
      r_irq <= (r_control[0] & ~w_rx_fifo_empty) | (r_control[1] & w_tx_empty);
    end
  end

  // ---------------------------------------------------------------- TX
  assign w_tx_bit_done = (r_tx_cnt == r_tx_div - 16'd1);
  assign w_tx_empty    = w_tx_fifo_empty & (r_tx_state == TX_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_tx_state <= TX_IDLE;
    else        r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_load = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_tx_fifo_empty) begin
          w_tx_next = TX_START;
          w_tx_load = 1'b1;
        end
      end
      TX_START: if (w_tx_bit_done) w_tx_next = TX_DATA;
      TX_DATA:  if (w_tx_bit_done && r_tx_bitcnt == 3'd7) w_tx_next = TX_STOP;
      TX_STOP: begin
        if (w_tx_bit_done) begin
          if (!w_tx_fifo_empty) begin
            w_tx_next = TX_START;
            w_tx_load = 1'b1;
          end else begin
            w_tx_next = TX_IDLE;
          end
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // The line is re-timed from the state, so tx lags the state machine by one clock
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tx_cnt    <= '0;
      r_tx_div    <= DEFAULT_DIVISOR;
      r_tx_shift  <= '0;
      r_tx_bitcnt <= '0;
      r_tx        <= 1'b1;
    end else begin
      if (w_tx_load) begin
        r_tx_shift  <= w_tx_head;
        r_tx_div    <= r_divisor;
        r_tx_cnt    <= '0;
        r_tx_bitcnt <= '0;
      end else if (r_tx_state != TX_IDLE) begin
        if (w_tx_bit_done) begin
          r_tx_cnt <= '0;
          if (r_tx_state == TX_DATA) begin
            r_tx_shift  <= {1'b0, r_tx_shift[7:1]};
            r_tx_bitcnt <= r_tx_bitcnt + 3'd1;
          end
        end else begin
          r_tx_cnt <= r_tx_cnt + 16'd1;
        end
      end
      case (r_tx_state)
        TX_START: r_tx <= 1'b0;
        TX_DATA:  r_tx <= r_tx_shift[0];
        default:  r_tx <= 1'b1;
      endcase
    end
  end

  assign tx = r_tx;

  // ---------------------------------------------------------------- RX
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_rx_sample = (r_rx_state == RX_HALF) ? (r_rx_cnt == (r_rx_div >> 1) - 16'd1)
                                               : (r_rx_cnt == r_rx_div - 16'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_rx_state <= RX_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next      = r_rx_state;
    w_rx_push_req  = 1'b0;
    w_rx_frame_err = 1'b0;
    case (r_rx_state)
      RX_IDLE: if (!r_rx_sync) w_rx_next = RX_HALF;
      RX_HALF: if (w_rx_sample) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA: if (w_rx_sample && r_rx_bitcnt == 3'd7) w_rx_next = RX_STOP;
      RX_STOP: begin
        if (w_rx_sample) begin
          if (r_rx_sync) begin
            w_rx_push_req = 1'b1;
            w_rx_next     = RX_IDLE;
          end else begin
            w_rx_frame_err = 1'b1;
            w_rx_next      = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: if (r_rx_sync) w_rx_next = RX_IDLE;
      default:      w_rx_next = RX_IDLE;
    endcase
  end

  // Divisor is captured at the start edge so a mid-character write cannot skew sampling
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_cnt    <= '0;
      r_rx_div    <= DEFAULT_DIVISOR;
      r_rx_shift  <= '0;
      r_rx_bitcnt <= '0;
    end else if (r_rx_state == RX_IDLE) begin
      r_rx_cnt    <= '0;
      r_rx_bitcnt <= '0;
      if (!r_rx_sync) r_rx_div <= r_divisor;
    end else if (w_rx_sample) begin
      r_rx_cnt <= '0;
      if (r_rx_state == RX_DATA) begin
        r_rx_shift  <= {r_rx_sync, r_rx_shift[7:1]};
        r_rx_bitcnt <= r_rx_bitcnt + 3'd1;
      end
    end else begin
      r_rx_cnt <= r_rx_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------- Read mux
  always_comb begin
    data_out = '0;
    if (w_rd) begin
      case (address)
        c_ADDR_DATA:    data_out = w_rx_fifo_empty ? 32'd0 : {24'd0, w_rx_head};
        c_ADDR_STATUS:  data_out = {26'd0, r_framing, r_overrun, w_tx_empty,
                                    w_tx_fifo_full, w_rx_fifo_full, ~w_rx_fifo_empty};
        c_ADDR_DIVISOR: data_out = {16'd0, r_divisor};
        default:        data_out = {30'd0, r_control};
      endcase
    end
  end

  assign irq = r_irq;
endmodule
`default_nettype wire
